cfu_rr_arbiter: RTL and testbench
=================================

// Module: cfu_rr_arbiter
// PURPOSE
//  Shares one CFU (e.g. the sig0/sig1 SHA-256 L3 units) between N requesters.
//  Round-robin arbitration on the request channel, in-order response return.
//  Each accepted request records its requester index in a route FIFO.
//  The FIFO head steers the shared CFU response back to its originator.
//  Sits between core-side CFU issue ports and one cfu_interface.master.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..8
//  ID_W         3   width of req_id/resp_id
//  MAX_OUTST    4   route FIFO depth = max outstanding requests, power of 2, >=2
// PORTS
//  clk            in   1              clock; single clock domain
//  rst_n          in   1              async active-low reset
//  s_req_valid    in   NUM_REQ        per-requester request valid
//  s_req_ready    out  NUM_REQ        per-requester request accept
//  s_req_id       in   NUM_REQ*ID_W   per-requester request id
//  s_rs1          in   NUM_REQ*32     per-requester operand 1
//  s_rs2          in   NUM_REQ*32     per-requester operand 2
//  s_resp_valid   out  NUM_REQ        per-requester response valid
//  s_resp_ready   in   NUM_REQ        per-requester response accept
//  s_resp_id      out  ID_W           response id, broadcast; qualified by s_resp_valid
//  s_resp_status  out  3              response status, broadcast
//  s_resp_data    out  32             response data, broadcast
//  cfu            --   interface      cfu_interface.master to the shared CFU
//  err_orphan     out  1              sticky: CFU responded with route FIFO empty
// BEHAVIOUR
//  Interface: one clock (clk). Reset is asynchronous, active-low (rst_n).
//  Reset state: rr pointer=0, lock=0, FIFO empty, err_orphan=0.
//   Also s_req_ready=0, s_resp_valid=0, cfu.req_valid=0, cfu.resp_ready=0.
//  Arbitration: grant = first valid requester at or after rr pointer, wrapping.
//   Combinational, zero added latency.
//   cfu.req_valid = s_req_valid[grant] & !fifo_full. id/rs1/rs2 mux from grant.
//   s_req_ready[grant] = cfu.req_ready & !fifo_full; all others are 0.
//  Lock: if the granted request is valid but not accepted, set lock=1.
//   While locked, the grant holds that index, even if a lower-priority requester rises.
//   Lock clears on the handshake.
//  On request handshake:
//   push grant index into the FIFO.
//   rr pointer <= grant+1 mod NUM_REQ.
//  Full: no accept while full, even if a pop occurs in the same cycle (no bypass).
//  Response: head = FIFO head index.
//   s_resp_valid[head] = cfu.resp_valid & !fifo_empty; others are 0.
//   cfu.resp_ready = s_resp_ready[head] & !fifo_empty.
//   Pop on response handshake.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//   Pointers wrap mod MAX_OUTST.
//  Empty FIFO with cfu.resp_valid=1: drop nothing. Hold cfu.resp_ready=0.
//   Set err_orphan (sticky until reset).
//  Responses return in issue order. The shared CFU must be in-order, which sig0/sig1 are.
//  Reset mid-operation clears all in-flight routing. The shared CFU is reset by the same rst_n.
//  No combinational path from s_resp_ready to s_req_ready.
// STRUCTURE
//  cfu_arb_pkg: REQ_IDX_W = $clog2(NUM_REQ) helper.
//   Also CFU_STATUS_OK=3'd0 and the cfu_status_t typedef.
//  Sub-module cfu_route_fifo: DEPTH x REQ_IDX_W register FIFO.
//   Has push/pop/full/empty/head and async active-low reset.
//  Top level holds the rr pointer, lock flag, grant logic, muxes and err_orphan.
// TESTING
//  1. All 4 requesters valid, CFU always ready, 1-cycle resp:
//     -> grants 0,1,2,3,0; each response reaches the issuing requester only.
//  2. Only req2 valid: 3 back-to-back requests are accepted each cycle.
//     -> rr pointer=3 after the first; responses id-match.
//  3. CFU req_ready=0 for 5 cycles while req1 pending, then req0 raises valid.
//     -> lock holds grant=1; req1 accepted first.
//  4. CFU resp_ready stalled (s_resp_ready=0), 5 requests issued.
//     -> 4 accepted, 5th blocked until first pop; no push when full.
//  5. Inject cfu.resp_valid with FIFO empty.
//     -> cfu.resp_ready=0, err_orphan=1, no s_resp_valid.
//  6. Deassert rst_n with 3 outstanding.
//     -> all outputs at reset values same cycle; FIFO empty after release.

Source files
------------

// File: rtl/cfu_arb_pkg.sv
// Shared types and helpers for the CFU round-robin arbiter.
package cfu_arb_pkg;

    typedef logic [2:0] cfu_status_t;

    localparam cfu_status_t CFU_STATUS_OK = 3'd0;

    // Width of a requester index; never narrower than one bit.
    function automatic int req_idx_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/cfu_rr_arbiter_if.sv
// Request/response channel to a shared custom function unit.
interface cfu_interface import cfu_arb_pkg::*; #(
    parameter int ID_W = 3
) ();

    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic [31:0]     req_rs1;
    logic [31:0]     req_rs2;

    logic            resp_valid;
    logic            resp_ready;
    logic [ID_W-1:0] resp_id;
    cfu_status_t     resp_status;
    logic [31:0]     resp_data;

    modport master (
        output req_valid, req_id, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_id, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_status, resp_data
    );

endinterface

// File: rtl/cfu_rr_arbiter_route_fifo.sv
// Register FIFO of requester indices; head steers in-order CFU responses.
module cfu_route_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_idx,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cfu_rr_arbiter.sv
// Round-robin front end sharing one in-order CFU between NUM_REQ requesters;
// responses are routed back through a FIFO of issuing requester indices.
module cfu_rr_arbiter import cfu_arb_pkg::*; #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_req_valid,
    output logic [NUM_REQ-1:0]            s_req_ready,
    input  logic [NUM_REQ-1:0][ID_W-1:0]  s_req_id,
    input  logic [NUM_REQ-1:0][31:0]      s_rs1,
    input  logic [NUM_REQ-1:0][31:0]      s_rs2,
    output logic [NUM_REQ-1:0]            s_resp_valid,
    input  logic [NUM_REQ-1:0]            s_resp_ready,
    output logic [ID_W-1:0]               s_resp_id,
    output cfu_status_t                   s_resp_status,
    output logic [31:0]                   s_resp_data,
    cfu_interface.master                  cfu,
    output logic                          err_orphan
);

    localparam int IDX_W = req_idx_w(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic [IDX_W-1:0] rr_grant;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_ok;
    logic             resp_ok;
    logic             req_hs;
    logic             resp_hs;

    // First valid requester at or after ptr, wrapping; ptr itself if none.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   ptr);
        int idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (v[idx[IDX_W-1:0]]) rr_pick = idx[IDX_W-1:0];
        end
    endfunction

    assign rr_grant = rr_pick(s_req_valid, rr_ptr);
    assign grant    = lock ? lock_idx : rr_grant;

    // Handshake outputs are forced low while reset is asserted.
    assign req_ok  = rst_n & ~fifo_full;
    assign resp_ok = rst_n & ~fifo_empty;

    assign cfu.req_valid = s_req_valid[grant] & req_ok;
    assign cfu.req_id    = s_req_id[grant];
    assign cfu.req_rs1   = s_rs1[grant];
    assign cfu.req_rs2   = s_rs2[grant];
    assign req_hs        = cfu.req_valid & cfu.req_ready;

    assign cfu.resp_ready = s_resp_ready[head] & resp_ok;
    assign resp_hs        = cfu.resp_valid & cfu.resp_ready;

    assign s_resp_id     = cfu.resp_id;
    assign s_resp_status = cfu.resp_status;
    assign s_resp_data   = cfu.resp_data;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
        assign s_req_ready[r]  = (grant == IDX_W'(r)) & cfu.req_ready & req_ok;
        assign s_resp_valid[r] = (head == IDX_W'(r)) & cfu.resp_valid & resp_ok;
    end

    cfu_route_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IDX_W)
    ) u_route_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_hs),
        .push_idx (grant),
        .pop      (resp_hs),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    // A stalled grant (busy CFU or full FIFO) is pinned until it handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (req_hs) begin
                rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            end
            lock     <= s_req_valid[grant] & ~req_hs;
            lock_idx <= grant;
            if (cfu.resp_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfu_rr_arbiter.sv
// Directed bench for cfu_rr_arbiter with an in-order CFU stub and a queue model.
module tb_cfu_rr_arbiter;
    import cfu_arb_pkg::*;

    localparam int NR  = 4;
    localparam int IDW = 3;
    localparam int MO  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]           s_req_valid;
    logic [NR-1:0]           s_req_ready;
    logic [NR-1:0][IDW-1:0]  s_req_id;
    logic [NR-1:0][31:0]     s_rs1;
    logic [NR-1:0][31:0]     s_rs2;
    logic [NR-1:0]           s_resp_valid;
    logic [NR-1:0]           s_resp_ready;
    logic [IDW-1:0]          s_resp_id;
    cfu_status_t             s_resp_status;
    logic [31:0]             s_resp_data;
    logic                    err_orphan;

    cfu_interface #(.ID_W(IDW)) cfu ();

    cfu_rr_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .MAX_OUTST(MO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req_id      (s_req_id),
        .s_rs1         (s_rs1),
        .s_rs2         (s_rs2),
        .s_resp_valid  (s_resp_valid),
        .s_resp_ready  (s_resp_ready),
        .s_resp_id     (s_resp_id),
        .s_resp_status (s_resp_status),
        .s_resp_data   (s_resp_data),
        .cfu           (cfu),
        .err_orphan    (err_orphan)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // In-order CFU stub: answers one cycle after accept with rs1+rs2.
    bit             cfu_rdy = 1'b0;
    bit             inject  = 1'b0;
    logic [IDW-1:0] stub_id_q[$];
    logic [31:0]    stub_data_q[$];
    int             stub_cnt  = 0;
    logic [IDW-1:0] head_id   = '0;
    logic [31:0]    head_data = '0;
    bit             st_push, st_pop;
    logic [IDW-1:0] st_id;
    logic [31:0]    st_data;

    assign cfu.req_ready   = cfu_rdy;
    assign cfu.resp_valid  = (stub_cnt != 0) || inject;
    assign cfu.resp_id     = head_id;
    assign cfu.resp_data   = head_data;
    assign cfu.resp_status = CFU_STATUS_OK;

    always @(negedge clk) begin
        st_push = cfu.req_valid && cfu.req_ready;
        st_pop  = cfu.resp_valid && cfu.resp_ready;
        st_id   = cfu.req_id;
        st_data = cfu.req_rs1 + cfu.req_rs2;
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (st_pop && stub_id_q.size() > 0) begin
                void'(stub_id_q.pop_front());
                void'(stub_data_q.pop_front());
            end
            if (st_push) begin
                stub_id_q.push_back(st_id);
                stub_data_q.push_back(st_data);
            end
        end
        stub_cnt  = stub_id_q.size();
        head_id   = (stub_cnt > 0) ? stub_id_q[0] : '0;
        head_data = (stub_cnt > 0) ? stub_data_q[0] : '0;
    end

    always @(negedge rst_n) begin
        stub_id_q.delete();
        stub_data_q.delete();
        stub_cnt = 0;
    end

    // Model: round-robin pointer, pinned grant, outstanding route queue.
    typedef struct {
        int             idx;
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } ent_t;

    int   rr_m = 0;
    bit   lk_m = 1'b0;
    int   lk_idx_m = 0;
    bit   err_m = 1'b0;
    ent_t rq[$];
    int   acc_cnt = 0;
    int   grant_log[$];
    int   resp_cnt[NR];

    initial for (int i = 0; i < NR; i++) resp_cnt[i] = 0;

    always @(negedge clk) begin
        int g;
        bit full, was_empty, exp_v, exp_rr, hs, rhs;
        logic [NR-1:0] exp_rdy, exp_rv;
        if (!rst_n) begin
            chk("rst_req_ready", s_req_ready, '0);
            chk("rst_req_valid", cfu.req_valid, 1'b0);
            chk("rst_resp_ready", cfu.resp_ready, 1'b0);
            chk("rst_resp_valid", s_resp_valid, '0);
            chk("rst_err_orphan", err_orphan, 1'b0);
            rr_m = 0; lk_m = 0; lk_idx_m = 0; err_m = 0;
            rq.delete();
        end else begin
            g = -1;
            if (lk_m) g = lk_idx_m;
            else for (int k = 0; k < NR; k++)
                if (g < 0 && s_req_valid[(rr_m + k) % NR]) g = (rr_m + k) % NR;
            full      = (rq.size() == MO);
            was_empty = (rq.size() == 0);
            exp_v     = (g >= 0) && s_req_valid[g] && !full;
            exp_rdy   = '0;
            if (g >= 0 && cfu.req_ready && !full) exp_rdy[g] = 1'b1;
            chk("cfu_req_valid", cfu.req_valid, exp_v);
            chk("s_req_ready", s_req_ready & s_req_valid, exp_rdy & s_req_valid);
            if (exp_v) begin
                chk("cfu_req_id", cfu.req_id, s_req_id[g]);
                chk("cfu_req_rs1", cfu.req_rs1, s_rs1[g]);
                chk("cfu_req_rs2", cfu.req_rs2, s_rs2[g]);
            end
            exp_rv = '0;
            exp_rr = 1'b0;
            if (!was_empty) begin
                exp_rr = s_resp_ready[rq[0].idx];
                if (cfu.resp_valid) begin
                    exp_rv[rq[0].idx] = 1'b1;
                    chk("s_resp_id", s_resp_id, rq[0].id);
                    chk("s_resp_data", s_resp_data, rq[0].data);
                    chk("s_resp_status", s_resp_status, CFU_STATUS_OK);
                end
            end
            chk("s_resp_valid", s_resp_valid, exp_rv);
            chk("cfu_resp_ready", cfu.resp_ready, exp_rr);
            chk("err_orphan", err_orphan, err_m);
            for (int r = 0; r < NR; r++)
                if (s_resp_valid[r] && s_resp_ready[r]) resp_cnt[r]++;
            hs  = exp_v && cfu.req_ready;
            rhs = cfu.resp_valid && exp_rr;
            if (rhs) void'(rq.pop_front());
            if (hs) begin
                acc_cnt++;
                grant_log.push_back(g);
                rq.push_back('{g, s_req_id[g], s_rs1[g] + s_rs2[g]});
                rr_m = (g + 1) % NR;
            end
            lk_m = (g >= 0) && s_req_valid[g] && !hs;
            if (lk_m) lk_idx_m = g;
            if (cfu.resp_valid && was_empty) err_m = 1'b1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        int exp_g1[5];
        exp_g1 = '{0, 1, 2, 3, 0};
        for (int r = 0; r < NR; r++) begin
            s_req_id[r] = IDW'(r);
            s_rs1[r]    = 32'h1000 * (r + 1);
            s_rs2[r]    = 32'(r + 5);
        end
        // Reset with everything asking: handshake outputs must stay low.
        s_req_valid  = '1;
        s_resp_ready = '1;
        cfu_rdy      = 1'b1;
        #2;
        chk("reset_s_req_ready", s_req_ready, '0);
        chk("reset_cfu_req_valid", cfu.req_valid, 1'b0);
        chk("reset_cfu_resp_ready", cfu.resp_ready, 1'b0);
        chk("reset_err_orphan", err_orphan, 1'b0);
        step(2);
        s_req_valid = '0;
        rst_n = 1'b1;
        step(1);

        // 1: all requesters valid, grants rotate 0,1,2,3,0.
        base = grant_log.size();
        s_req_valid = 4'hF;
        step(5);
        s_req_valid = '0;
        chk("t1_accepts", grant_log.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < grant_log.size())
                chk($sformatf("t1_grant%0d", i), grant_log[base + i], exp_g1[i]);
        step(3);
        chk("t1_resp_r0", resp_cnt[0], 2);
        chk("t1_resp_r1", resp_cnt[1], 1);
        chk("t1_resp_r2", resp_cnt[2], 1);
        chk("t1_resp_r3", resp_cnt[3], 1);

        // 2: only req2, back-to-back accepts; pointer moves past it.
        base = acc_cnt;
        s_req_valid = 4'b0100;
        step(3);
        s_req_valid = '0;
        chk("t2_accepts", acc_cnt - base, 3);
        chk("t2_last_grant", grant_log[grant_log.size() - 1], 2);
        chk("t2_rr_ptr", rr_m, 3);
        step(3);
        chk("t2_resp_r2", resp_cnt[2], 4);

        // 3: CFU busy with req1 pending; req0 rising must not steal the grant.
        cfu_rdy = 1'b0;
        s_req_valid = 4'b0010;
        step(5);
        s_req_valid = 4'b0011;
        #1;
        chk("t3_locked_id", cfu.req_id, 1);
        chk("t3_locked_valid", cfu.req_valid, 1'b1);
        step(1);
        cfu_rdy = 1'b1;
        base = grant_log.size();
        step(2);
        s_req_valid = '0;
        chk("t3_first_grant", grant_log[base], 1);
        chk("t3_second_grant", grant_log[base + 1], 0);
        step(3);

        // 4: responses stalled; four fill the FIFO, fifth waits for a pop.
        s_resp_ready = '0;
        s_req_valid  = 4'b1000;
        base = acc_cnt;
        step(6);
        chk("t4_accepts_full", acc_cnt - base, 4);
        chk("t4_full_no_req", cfu.req_valid, 1'b0);
        s_resp_ready = 4'b1000;
        #1;
        chk("t4_pop_ready", cfu.resp_ready, 1'b1);
        chk("t4_no_bypass", cfu.req_valid, 1'b0);
        step(1);
        chk("t4_after_pop", acc_cnt - base, 4);
        step(1);
        s_req_valid = '0;
        chk("t4_fifth", acc_cnt - base, 5);
        s_resp_ready = '1;
        step(6);

        // 5: CFU response with nothing outstanding.
        inject = 1'b1;
        #1;
        chk("t5_resp_ready", cfu.resp_ready, 1'b0);
        chk("t5_s_resp_valid", s_resp_valid, '0);
        step(1);
        chk("t5_err_orphan", err_orphan, 1'b1);
        inject = 1'b0;
        step(1);
        chk("t5_err_sticky", err_orphan, 1'b1);

        // 6: reset with three requests outstanding.
        s_resp_ready = '0;
        s_req_valid  = 4'b0001;
        step(3);
        s_req_valid = '0;
        step(1);
        chk("t6_outstanding", rq.size(), 3);
        s_req_valid  = 4'b0001;
        s_resp_ready = '1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req_ready", s_req_ready, '0);
        chk("t6_rst_req_valid", cfu.req_valid, 1'b0);
        chk("t6_rst_resp_ready", cfu.resp_ready, 1'b0);
        chk("t6_rst_resp_valid", s_resp_valid, '0);
        chk("t6_rst_err", err_orphan, 1'b0);
        step(1);
        s_req_valid = '0;
        rst_n = 1'b1;
        step(1);
        chk("t6_empty_resp_ready", cfu.resp_ready, 1'b0);
        chk("t6_empty_resp_valid", s_resp_valid, '0);
        base = grant_log.size();
        s_req_valid = 4'b0010;
        step(1);
        s_req_valid = '0;
        chk("t6_post_grant", grant_log[base], 1);
        step(3);
        chk("t6_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
